// File: rtl/logic_engine_bridge.sv
`timescale 1ns/1ps
// logic_engine_bridge: turns the CPU level-request / one-cycle-ack logic port into a
//   valid/ready request channel plus a valid-only response channel toward the engine.
// Latency: req seen at edge k -> eng_req_valid after k+1; response at edge n -> ack after n+1.
// Backpressure: eng_req_valid/eng_req_addr are held until eng_req_ready or timeout; the
//   bounded timer guarantees the CPU always gets an ack, even from a dead engine.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_logic_*         CPU side: req/addr in, ack pulse + data out
//   eng_req_*           engine request channel (valid/ready, latched address)
//   eng_rsp_*           engine response strobe, data and error flag
//   err_clr             clears both sticky error flags (a coincident set wins)
//   busy                high whenever the bridge is not IDLE
//   err_timeout/engine  sticky error flags
//   stat_*              optional saturating counters, present only when the
//                       LOGIC_BRIDGE_STATS_EN macro is defined
module logic_engine_bridge #(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       TIMEOUT_CYCLES = 64,
   parameter logic [DATA_W-1:0] TO_DATA        = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_logic_req,
   input  logic [ADDR_W-1:0] cpu_logic_addr,
   output logic              cpu_logic_ack,
   output logic [DATA_W-1:0] cpu_logic_data,
   output logic              eng_req_valid,
   input  logic              eng_req_ready,
   output logic [ADDR_W-1:0] eng_req_addr,
   input  logic              eng_rsp_valid,
   input  logic [DATA_W-1:0] eng_rsp_data,
   input  logic              eng_rsp_err,
   input  logic              err_clr,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_engine
`ifdef LOGIC_BRIDGE_STATS_EN
   ,
   output logic [15:0]       stat_req_count,
   output logic [15:0]       stat_timeout_count
`endif
);

   localparam int unsigned      TMR_W    = 16;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              vld_q;
   logic              ack_q;
   logic              busy_q;
   logic              err_to_q;
   logic              err_eng_q;

   logic              hs;
   logic              tmr_exp;
   logic              rsp_take;
   logic              to_fire;
   logic              eng_set;
   logic              start_issue;

   assign hs          = vld_q & eng_req_ready;
   // >= rather than == : a handshake on the last ISSUE cycle enters WAIT with the
   // timer already at its limit, and WAIT must then expire on its first cycle.
   assign tmr_exp     = (timer_q >= TMR_LAST);
   assign rsp_take    = (state_q == S_WAIT) & eng_rsp_valid;
   // A response on the expiry cycle takes priority over the timeout.
   assign to_fire     = ((state_q == S_ISSUE) & ~hs & tmr_exp) |
                        ((state_q == S_WAIT) & ~eng_rsp_valid & tmr_exp);
   assign eng_set     = rsp_take & eng_rsp_err;
   assign start_issue = (state_q == S_IDLE) & cpu_logic_req;

`ifdef LOGIC_BRIDGE_STATS_EN
   logic [15:0] req_cnt_q;
   logic [15:0] to_cnt_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         vld_q     <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_to_q  <= 1'b0;
         err_eng_q <= 1'b0;
`ifdef LOGIC_BRIDGE_STATS_EN
         req_cnt_q <= '0;
         to_cnt_q  <= '0;
`endif
      end else begin
         ack_q <= 1'b0;

         if ((state_q == S_ISSUE || state_q == S_WAIT) && !tmr_exp) begin
            timer_q <= timer_q + 16'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (cpu_logic_req) begin
                  addr_q  <= cpu_logic_addr;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // valid rises one cycle after ISSUE entry, so no handshake is
               // possible on the entry cycle itself.
               if (hs) begin
                  vld_q   <= 1'b0;
                  state_q <= S_WAIT;
               end else if (tmr_exp) begin
                  vld_q   <= 1'b0;
                  data_q  <= TO_DATA;
                  state_q <= S_RESP;
               end else begin
                  vld_q   <= 1'b1;
               end
            end
            S_WAIT: begin
               if (eng_rsp_valid) begin
                  data_q  <= eng_rsp_data;
                  state_q <= S_RESP;
               end else if (tmr_exp) begin
                  data_q  <= TO_DATA;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               ack_q   <= 1'b1;
               state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // Hold off re-issue until the CPU has released its request.
               if (!cpu_logic_req) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase

         // Set beats clear when both happen in the same cycle.
         err_to_q  <= to_fire | (err_to_q & ~err_clr);
         err_eng_q <= eng_set | (err_eng_q & ~err_clr);

`ifdef LOGIC_BRIDGE_STATS_EN
         if (start_issue && req_cnt_q != 16'hFFFF) begin
            req_cnt_q <= req_cnt_q + 16'd1;
         end
         if (to_fire && to_cnt_q != 16'hFFFF) begin
            to_cnt_q <= to_cnt_q + 16'd1;
         end
`endif
      end
   end

   assign cpu_logic_ack  = ack_q;
   assign cpu_logic_data = data_q;
   assign eng_req_valid  = vld_q;
   assign eng_req_addr   = addr_q;
   assign busy           = busy_q;
   assign err_timeout    = err_to_q;
   assign err_engine     = err_eng_q;

`ifdef LOGIC_BRIDGE_STATS_EN
   assign stat_req_count     = req_cnt_q;
   assign stat_timeout_count = to_cnt_q;
`endif

endmodule

// File: tb/tb_logic_engine_bridge.sv
`timescale 1ns/1ps
// Bench for logic_engine_bridge: instance "dut" uses the default 64-cycle timeout,
// instance "dut_to" uses an 8-cycle timeout for the timeout tests. Expected CPU acks
// are queued as stimulus is issued and popped by per-instance ack monitors.
module tb_logic_engine_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // instance A (TIMEOUT_CYCLES = 64)
   logic        cpu_logic_req, cpu_logic_ack, eng_req_valid, eng_req_ready;
   logic [31:0] cpu_logic_addr, cpu_logic_data, eng_req_addr, eng_rsp_data;
   logic        eng_rsp_valid, eng_rsp_err, err_clr, busy, err_timeout, err_engine;
   // instance B (TIMEOUT_CYCLES = 8)
   logic        t_req, t_ack, t_vld, t_rdy, t_rsp_v, t_rsp_e, t_clr, t_busy, t_eto, t_eeng;
   logic [31:0] t_addr, t_data, t_eaddr, t_rsp_d;
`ifdef LOGIC_BRIDGE_STATS_EN
   logic [15:0] stat_req_count, stat_timeout_count, t_sreq, t_sto;
`endif

   logic_engine_bridge #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .cpu_logic_req(cpu_logic_req), .cpu_logic_addr(cpu_logic_addr),
      .cpu_logic_ack(cpu_logic_ack), .cpu_logic_data(cpu_logic_data),
      .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
      .eng_req_addr(eng_req_addr), .eng_rsp_valid(eng_rsp_valid),
      .eng_rsp_data(eng_rsp_data), .eng_rsp_err(eng_rsp_err),
      .err_clr(err_clr), .busy(busy), .err_timeout(err_timeout), .err_engine(err_engine)
`ifdef LOGIC_BRIDGE_STATS_EN
      , .stat_req_count(stat_req_count), .stat_timeout_count(stat_timeout_count)
`endif
   );

   logic_engine_bridge #(.TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .rst(rst),
      .cpu_logic_req(t_req), .cpu_logic_addr(t_addr),
      .cpu_logic_ack(t_ack), .cpu_logic_data(t_data),
      .eng_req_valid(t_vld), .eng_req_ready(t_rdy),
      .eng_req_addr(t_eaddr), .eng_rsp_valid(t_rsp_v),
      .eng_rsp_data(t_rsp_d), .eng_rsp_err(t_rsp_e),
      .err_clr(t_clr), .busy(t_busy), .err_timeout(t_eto), .err_engine(t_eeng)
`ifdef LOGIC_BRIDGE_STATS_EN
      , .stat_req_count(t_sreq), .stat_timeout_count(t_sto)
`endif
   );

   typedef struct packed {
      logic [31:0] d;
      logic        to;
      logic        eng;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t ea, eb;
   int   total = 0;
   int   bad   = 0;
   int   ack_a = 0;
   int   ack_b = 0;
   int   hs_a  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: each ack pops one expected entry.
   always @(negedge clk) begin
      if (!rst && cpu_logic_ack) begin
         ack_a++;
         if (exp_a.size() == 0) begin
            chk("ackA_unexpected", 64'd1, 64'd0);
         end else begin
            ea = exp_a.pop_front();
            chk("ackA_data", cpu_logic_data, ea.d);
            chk("ackA_err_timeout", err_timeout, ea.to);
            chk("ackA_err_engine", err_engine, ea.eng);
         end
      end
      if (!rst && eng_req_valid && eng_req_ready) hs_a++;
   end

   always @(negedge clk) begin
      if (!rst && t_ack) begin
         ack_b++;
         if (exp_b.size() == 0) begin
            chk("ackB_unexpected", 64'd1, 64'd0);
         end else begin
            eb = exp_b.pop_front();
            chk("ackB_data", t_data, eb.d);
            chk("ackB_err_timeout", t_eto, eb.to);
            chk("ackB_err_engine", t_eeng, eb.eng);
         end
      end
   end

   task automatic wait_vld(input string nm, output int n);
      n = 0;
      while (!eng_req_valid && n < 20) begin
         tick();
         n++;
      end
      chk(nm, eng_req_valid, 1);
   endtask

   task automatic wait_ack_a(input string nm);
      int b;
      int n;
      b = ack_a;
      n = 0;
      while (ack_a == b && n < 40) begin
         tick();
         n++;
      end
      chk(nm, ack_a, b + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int hs0;
      int a0;
`ifdef LOGIC_BRIDGE_STATS_EN
      logic [15:0] s0;
`endif
      rst = 1'b1;
      cpu_logic_req = 0; cpu_logic_addr = 0; eng_req_ready = 0;
      eng_rsp_valid = 0; eng_rsp_data = 0; eng_rsp_err = 0; err_clr = 0;
      t_req = 0; t_addr = 0; t_rdy = 1; t_rsp_v = 0; t_rsp_d = 0; t_rsp_e = 0; t_clr = 0;
      repeat (3) tick();

      // reset state
      chk("rst_valid", eng_req_valid, 0);
      chk("rst_ack", cpu_logic_ack, 0);
      chk("rst_data", cpu_logic_data, 0);
      chk("rst_addr", eng_req_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_timeout, err_engine}, 0);
      chk("rst_B_valid", t_vld, 0);
      rst = 1'b0;
      tick();

      // timeout on B: ack 9 cycles after ISSUE entry, late response ignored
      t_req = 1; t_addr = 32'h200;
      exp_b.push_back('{d: 32'hFFFF_FFFF, to: 1'b1, eng: 1'b0});
      tick();
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 8) chk("to_ack_early", t_ack, 0);
         if (i == 9) chk("to_ack_at_9", t_ack, 1);
      end
      t_req = 0;
      repeat (3) tick();
      t_rsp_v = 1; t_rsp_d = 32'h1111_2222;
      tick();
      t_rsp_v = 0;
      repeat (4) tick();
      chk("to_single_ack", ack_b, 1);
      chk("to_flag_sticky", t_eto, 1);
      chk("to_busy_idle", t_busy, 0);

      // response on the expiry cycle beats the timeout
      t_clr = 1; tick(); t_clr = 0;
      chk("to_clr", t_eto, 0);
      t_req = 1; t_addr = 32'h204;
      tick();
      repeat (7) tick();
      t_rsp_v = 1; t_rsp_d = 32'h0000_0077;
      exp_b.push_back('{d: 32'h0000_0077, to: 1'b0, eng: 1'b0});
      tick();
      t_rsp_v = 0;
      chk("expiry_rsp_wins", t_eto, 0);
      repeat (2) tick();
      t_req = 0;
      repeat (3) tick();
      chk("expiry_ack_count", ack_b, 2);

      // basic transaction on A
      eng_req_ready = 1;
      cpu_logic_req = 1; cpu_logic_addr = 32'h0000_0040;
      wait_vld("basic_vld", n);
      chk("basic_vld_latency", n, 2);
      chk("basic_addr", eng_req_addr, 32'h40);
      tick();
      chk("basic_vld_drop", eng_req_valid, 0);
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'hABCD_1234;
      exp_a.push_back('{d: 32'hABCD_1234, to: 1'b0, eng: 1'b0});
      tick();
      eng_rsp_valid = 0;
      chk("basic_ack_not_yet", cpu_logic_ack, 0);
      tick();
      chk("basic_ack", cpu_logic_ack, 1);
      cpu_logic_req = 0;
      repeat (2) tick();
      chk("basic_busy_low", busy, 0);
      chk("basic_ack_count", ack_a, 1);

      // backpressure: ready low for 5 cycles, addr changes ignored
      eng_req_ready = 0;
      cpu_logic_req = 1; cpu_logic_addr = 32'h80;
      wait_vld("bp_vld", n);
      cpu_logic_addr = 32'hDEAD_BEEF;
      hs0 = hs_a;
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld_held", eng_req_valid, 1);
         chk("bp_addr_held", eng_req_addr, 32'h80);
         tick();
      end
      eng_req_ready = 1;
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'h5A5A_A5A5;
      exp_a.push_back('{d: 32'h5A5A_A5A5, to: 1'b0, eng: 1'b0});
      tick();
      eng_rsp_valid = 0;
      wait_ack_a("bp_ack");
      cpu_logic_req = 0;
      repeat (2) tick();
      chk("bp_one_handshake", hs_a - hs0, 1);

      // engine error, clear, and clear coinciding with a new error
      cpu_logic_req = 1; cpu_logic_addr = 32'h44;
      wait_vld("err_vld", n);
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'h1234_5678; eng_rsp_err = 1;
      exp_a.push_back('{d: 32'h1234_5678, to: 1'b0, eng: 1'b1});
      tick();
      eng_rsp_valid = 0; eng_rsp_err = 0;
      wait_ack_a("err_ack");
      chk("err_flag_set", err_engine, 1);
      cpu_logic_req = 0;
      tick();
      err_clr = 1; tick(); err_clr = 0;
      chk("err_flag_cleared", err_engine, 0);
      cpu_logic_req = 1; cpu_logic_addr = 32'h48;
      wait_vld("err2_vld", n);
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'h0BAD_0BAD; eng_rsp_err = 1; err_clr = 1;
      exp_a.push_back('{d: 32'h0BAD_0BAD, to: 1'b0, eng: 1'b1});
      tick();
      eng_rsp_valid = 0; eng_rsp_err = 0; err_clr = 0;
      chk("err_set_beats_clr", err_engine, 1);
      wait_ack_a("err2_ack");
      cpu_logic_req = 0;
      tick();
      err_clr = 1; tick(); err_clr = 0;
      chk("err_flag_cleared2", err_engine, 0);

      // held request: no re-issue while in DRAIN
`ifdef LOGIC_BRIDGE_STATS_EN
      s0 = stat_req_count;
`endif
      cpu_logic_req = 1; cpu_logic_addr = 32'h100;
      wait_vld("held_vld", n);
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'hCAFE_F00D;
      exp_a.push_back('{d: 32'hCAFE_F00D, to: 1'b0, eng: 1'b0});
      tick();
      eng_rsp_valid = 0;
      wait_ack_a("held_ack1");
      hs0 = hs_a;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("held_no_vld", eng_req_valid, 0);
         chk("held_busy", busy, 1);
      end
      chk("held_no_handshake", hs_a - hs0, 0);
      cpu_logic_req = 0;
      repeat (2) tick();
      chk("held_idle", busy, 0);
      cpu_logic_req = 1; cpu_logic_addr = 32'h104;
      wait_vld("held_reissue", n);
      chk("held_reissue_addr", eng_req_addr, 32'h104);
      tick();
      eng_rsp_valid = 1; eng_rsp_data = 32'h0F0F_0F0F;
      exp_a.push_back('{d: 32'h0F0F_0F0F, to: 1'b0, eng: 1'b0});
      tick();
      eng_rsp_valid = 0;
      wait_ack_a("held_ack2");
      cpu_logic_req = 0;
      repeat (2) tick();
`ifdef LOGIC_BRIDGE_STATS_EN
      chk("stat_req_count_delta", stat_req_count - s0, 2);
      chk("stat_timeout_B", t_sto, 1);
`endif

      // reset during WAIT
      cpu_logic_req = 1; cpu_logic_addr = 32'h300;
      wait_vld("rstw_vld", n);
      tick();
      chk("rstw_in_wait", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstw_valid", eng_req_valid, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_ack", cpu_logic_ack, 0);
      chk("rstw_data", cpu_logic_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cpu_logic_req = 0;
      a0 = ack_a;
      eng_rsp_valid = 1; eng_rsp_data = 32'h5555_5555;
      tick();
      eng_rsp_valid = 0;
      repeat (4) tick();
      chk("rstw_stale_no_ack", ack_a - a0, 0);
      chk("rstw_idle", busy, 0);

      chk("scoreboard_a_empty", exp_a.size(), 0);
      chk("scoreboard_b_empty", exp_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
